// File: rtl/fll_reg_endpoint.sv
// FLL-side endpoint of the FLL_BUS 4-phase req/ack handshake.
// Synchronises req_i, holds the FLL configuration registers and serves reads/writes.
module fll_reg_endpoint #(
    parameter logic [31:0] CFG1_RST  = 32'h0000_0000,
    parameter logic [31:0] CFG2_RST  = 32'h0000_0000,
    parameter logic [31:0] INTEG_RST = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        wrn_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    input  logic        lock_i,
    input  logic [15:0] freq_cnt_i,
    output logic [31:0] cfg1_o,
    output logic [31:0] cfg2_o,
    output logic [31:0] integ_o,
    output logic        cfg_upd_o,
    output logic [1:0]  cfg_upd_idx_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        req_meta_q, req_s_q;
    logic        wrn_q, wrn_d;
    logic [1:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic        upd_q, upd_d;
    logic [1:0]  upd_idx_q, upd_idx_d;
    logic [31:0] cfg1_q, cfg1_d;
    logic [31:0] cfg2_q, cfg2_d;
    logic [31:0] integ_q, integ_d;
    logic [31:0] rd_mux;

    // Two-flop synchroniser for the request coming from the bridge clock domain
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_meta_q <= 1'b0;
            req_s_q    <= 1'b0;
        end else begin
            req_meta_q <= req_i;
            req_s_q    <= req_meta_q;
        end
    end

    // Read-data selection; REG0 is live status sampled when the access executes
    always_comb begin
        rd_mux = 32'd0;
        case (addr_q)
            2'd0:    rd_mux = {lock_i, 15'd0, freq_cnt_i};
            2'd1:    rd_mux = cfg1_q;
            2'd2:    rd_mux = cfg2_q;
            2'd3:    rd_mux = integ_q;
            default: rd_mux = 32'd0;
        endcase
    end

    // Handshake FSM next-state, register writes and read capture
    always_comb begin
        state_d   = state_q;
        wrn_d     = wrn_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ack_d     = ack_q;
        rdata_d   = rdata_q;
        upd_d     = 1'b0;
        upd_idx_d = upd_idx_q;
        cfg1_d    = cfg1_q;
        cfg2_d    = cfg2_q;
        integ_d   = integ_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s_q) begin
                    wrn_d   = wrn_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE: state_d = ST_ACCESS;
            ST_ACCESS: begin
                ack_d   = 1'b1;
                state_d = ST_ACK;
                if (wrn_q) begin
                    rdata_d = rd_mux;
                end else begin
                    // A write to the status word is acknowledged but otherwise dropped
                    case (addr_q)
                        2'd1: begin cfg1_d  = wdata_q; upd_d = 1'b1; upd_idx_d = 2'd1; end
                        2'd2: begin cfg2_d  = wdata_q; upd_d = 1'b1; upd_idx_d = 2'd2; end
                        2'd3: begin integ_d = wdata_q; upd_d = 1'b1; upd_idx_d = 2'd3; end
                        default: upd_d = 1'b0;
                    endcase
                end
            end
            ST_ACK: begin
                if (!req_s_q) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACK;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            wrn_q     <= 1'b1;
            addr_q    <= 2'd0;
            wdata_q   <= 32'd0;
            ack_q     <= 1'b0;
            rdata_q   <= 32'd0;
            upd_q     <= 1'b0;
            upd_idx_q <= 2'd0;
            cfg1_q    <= CFG1_RST;
            cfg2_q    <= CFG2_RST;
            integ_q   <= INTEG_RST;
        end else begin
            state_q   <= state_d;
            wrn_q     <= wrn_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            upd_q     <= upd_d;
            upd_idx_q <= upd_idx_d;
            cfg1_q    <= cfg1_d;
            cfg2_q    <= cfg2_d;
            integ_q   <= integ_d;
        end
    end

    assign ack_o         = ack_q;
    assign rdata_o       = rdata_q;
    assign cfg1_o        = cfg1_q;
    assign cfg2_o        = cfg2_q;
    assign integ_o       = integ_q;
    assign cfg_upd_o     = upd_q;
    assign cfg_upd_idx_o = upd_idx_q;

endmodule

// File: tb/tb_fll_reg_endpoint.sv
// Directed, table-driven bench for fll_reg_endpoint: handshake latency, register map,
// update strobe, and reset in the middle of an access.
module tb_fll_reg_endpoint;

    localparam logic [31:0] C1_RST = 32'hA5A5_0001;
    localparam logic [31:0] C2_RST = 32'h0F0F_0002;
    localparam logic [31:0] IN_RST = 32'h0000_3C03;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        wrn_i = 1'b1;
    logic [1:0]  addr_i = 2'd0;
    logic [31:0] wdata_i = 32'd0;
    logic        lock_i = 1'b0;
    logic [15:0] freq_cnt_i = 16'd0;
    logic        ack_o, cfg_upd_o;
    logic [31:0] rdata_o, cfg1_o, cfg2_o, integ_o;
    logic [1:0]  cfg_upd_idx_o;

    int tests = 0;
    int failed = 0;
    logic [31:0] m_cfg1 = C1_RST;
    logic [31:0] m_cfg2 = C2_RST;
    logic [31:0] m_integ = IN_RST;

    typedef struct {
        logic        wrn;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        lock;
        logic [15:0] freq;
        logic [31:0] exp_rdata;
        logic        exp_upd;
        logic [1:0]  exp_idx;
    } vec_t;

    vec_t vecs[12];

    fll_reg_endpoint #(
        .CFG1_RST (C1_RST),
        .CFG2_RST (C2_RST),
        .INTEG_RST(IN_RST)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .wrn_i        (wrn_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .ack_o        (ack_o),
        .rdata_o      (rdata_o),
        .lock_i       (lock_i),
        .freq_cnt_i   (freq_cnt_i),
        .cfg1_o       (cfg1_o),
        .cfg2_o       (cfg2_o),
        .integ_o      (integ_o),
        .cfg_upd_o    (cfg_upd_o),
        .cfg_upd_idx_o(cfg_upd_idx_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_cfg(input string tag);
        chk({tag, "_cfg1"}, cfg1_o, m_cfg1);
        chk({tag, "_cfg2"}, cfg2_o, m_cfg2);
        chk({tag, "_integ"}, integ_o, m_integ);
    endtask

    function automatic vec_t mk(input logic wrn, input logic [1:0] addr, input logic [31:0] wdata,
                                input logic lock, input logic [15:0] freq,
                                input logic [31:0] exp_rdata, input logic exp_upd);
        vec_t v;
        v.wrn = wrn; v.addr = addr; v.wdata = wdata; v.lock = lock; v.freq = freq;
        v.exp_rdata = exp_rdata; v.exp_upd = exp_upd; v.exp_idx = addr;
        return v;
    endfunction

    task automatic run_vec(input int i, input vec_t v);
        int n;
        int upd_cnt;
        string tag;
        tag = $sformatf("v%0d", i);
        lock_i = v.lock;
        freq_cnt_i = v.freq;
        @(posedge clk_i); #1;
        req_i = 1'b1; wrn_i = v.wrn; addr_i = v.addr; wdata_i = v.wdata;
        n = 0;
        upd_cnt = 0;
        do begin
            @(posedge clk_i); n++;
            @(negedge clk_i);
            if (cfg_upd_o) upd_cnt++;
        end while (!ack_o && n < 20);
        chk({tag, "_ack_rise_edges"}, 32'(n), 32'd5);
        chk({tag, "_upd_at_ack_rise"}, {31'd0, cfg_upd_o}, {31'd0, v.exp_upd});
        if (v.exp_upd) chk({tag, "_upd_idx"}, {30'd0, cfg_upd_idx_o}, {30'd0, v.exp_idx});
        chk({tag, "_rdata"}, rdata_o, v.exp_rdata);
        if (!v.wrn) begin
            case (v.addr)
                2'd1:    m_cfg1 = v.wdata;
                2'd2:    m_cfg2 = v.wdata;
                2'd3:    m_integ = v.wdata;
                default: ;
            endcase
        end
        chk_cfg(tag);
        @(posedge clk_i); #1;
        req_i = 1'b0;
        n = 0;
        do begin
            @(posedge clk_i); n++;
            @(negedge clk_i);
            if (cfg_upd_o) upd_cnt++;
        end while (ack_o && n < 20);
        chk({tag, "_ack_fall_edges"}, 32'(n), 32'd3);
        chk({tag, "_upd_pulses"}, 32'(upd_cnt), {31'd0, v.exp_upd});
        chk({tag, "_rdata_hold"}, rdata_o, v.exp_rdata);
    endtask

    initial begin
        int n;
        vecs[0]  = mk(1'b1, 2'd1, 32'd0, 1'b0, 16'h0000, C1_RST, 1'b0);
        vecs[1]  = mk(1'b1, 2'd2, 32'd0, 1'b0, 16'h0000, C2_RST, 1'b0);
        vecs[2]  = mk(1'b1, 2'd3, 32'd0, 1'b0, 16'h0000, IN_RST, 1'b0);
        vecs[3]  = mk(1'b0, 2'd1, 32'hC0DE_0123, 1'b0, 16'h0000, IN_RST, 1'b1);
        vecs[4]  = mk(1'b1, 2'd0, 32'd0, 1'b1, 16'h1234, 32'h8000_1234, 1'b0);
        vecs[5]  = mk(1'b0, 2'd0, 32'hFFFF_FFFF, 1'b1, 16'h1234, 32'h8000_1234, 1'b0);
        vecs[6]  = mk(1'b1, 2'd0, 32'd0, 1'b0, 16'hABCD, 32'h0000_ABCD, 1'b0);
        vecs[7]  = mk(1'b0, 2'd2, 32'h5A5A_A5A5, 1'b0, 16'hABCD, 32'h0000_ABCD, 1'b1);
        vecs[8]  = mk(1'b1, 2'd2, 32'd0, 1'b0, 16'hABCD, 32'h5A5A_A5A5, 1'b0);
        vecs[9]  = mk(1'b0, 2'd3, 32'hDEAD_BEEF, 1'b0, 16'hABCD, 32'h5A5A_A5A5, 1'b1);
        vecs[10] = mk(1'b1, 2'd3, 32'd0, 1'b0, 16'hABCD, 32'hDEAD_BEEF, 1'b0);
        vecs[11] = mk(1'b1, 2'd1, 32'd0, 1'b0, 16'hABCD, 32'hC0DE_0123, 1'b0);

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_ack", {31'd0, ack_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_upd", {31'd0, cfg_upd_o}, 32'd0);
        chk("rst_upd_idx", {30'd0, cfg_upd_idx_o}, 32'd0);
        chk_cfg("rst");
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Reset while the FSM is in ACCESS, request held high throughout
        @(posedge clk_i); #1;
        req_i = 1'b1; wrn_i = 1'b0; addr_i = 2'd1; wdata_i = 32'h1234_5678;
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        chk("pre_rst_ack", {31'd0, ack_o}, 32'd0);
        rst_i = 1'b1;
        #1;
        m_cfg1 = C1_RST; m_cfg2 = C2_RST; m_integ = IN_RST;
        chk("midrst_ack", {31'd0, ack_o}, 32'd0);
        chk("midrst_rdata", rdata_o, 32'd0);
        chk("midrst_upd", {31'd0, cfg_upd_o}, 32'd0);
        chk_cfg("midrst");
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        n = 0;
        do begin
            @(posedge clk_i); n++;
            @(negedge clk_i);
        end while (!ack_o && n < 20);
        chk("redo_ack_rise_edges", 32'(n), 32'd5);
        chk("redo_upd", {31'd0, cfg_upd_o}, 32'd1);
        m_cfg1 = 32'h1234_5678;
        chk_cfg("redo");
        @(posedge clk_i); #1;
        req_i = 1'b0;
        n = 0;
        do begin
            @(posedge clk_i); n++;
            @(negedge clk_i);
        end while (ack_o && n < 20);
        chk("redo_ack_fall_edges", 32'(n), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
